hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
// - Consumer side of the decode/dependency interface: takes issued instructions, tracks in-flight destination registers across EX, MEM and WB, and drives operand-bypass selects.
// - Detects load-use hazards, stalls issue for one cycle and inserts an EX bubble.
// - Sits between decode and the EX-stage operand muxes; produces the WB register-write address.
// PARAMETERS
// - ADDR_W        5  register-address width (ins fields [25:21], [20:16], [15:11])
// - R0_HARDWIRED  1  1: destination 0 never writes and never matches
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   asynchronous, active-low; clears all state
// - ins        in   32  instruction; op = ins[31:26], D = [25:21], A = [20:16], B = [15:11]
// - ins_valid  in   1   ins present this cycle
// - ins_ready  out  1   0 = hold ins (stall); transfer occurs when ins_valid & ins_ready
// - mux_sel_A  out  2   00 regfile, 01 EX result, 10 MEM result, 11 WB result
// - mux_sel_B  out  2   same encoding for operand B
// - stall      out  1   combinational, equals ~ins_ready
// - RW_wb      out  5   WB-stage destination address
// - wb_en      out  1   WB-stage register write enable
// BEHAVIOUR
// - Decode: JMP=011000; CJ=0111xx; LD=010100; ST=010101; IMM=001xxx; everything else is ALU.
// - Writes D: ALU, IMM, LD. No write: JMP, CJ, ST.
// - Reads A: all except JMP.
// - Reads B: ALU, CJ, ST. IMM and LD never read B; their select is forced to 00.
// - State: three stage registers (EX, MEM, WB), each {valid, wr, is_ld, dest[ADDR_W-1:0]}. Each clock: WB<=MEM, MEM<=EX.
// - EX <= decoded ins when ins_valid & ins_ready; otherwise EX <= bubble (valid=0).
// - Match(s, src) = s.valid & s.wr & (s.dest == src) & ~(R0_HARDWIRED & dest == 0).
// - Select priority per operand: EX match -> 01, else MEM -> 10, else WB -> 11, else 00.
// - Selects are registered on the issue edge and valid during the instruction's EX cycle: latency 1.
// - Load-use: EX.is_ld and Match(EX, a used source) while ins_valid -> ins_ready = 0 for exactly that cycle, bubble into EX.
// - On the next cycle the LD is in MEM; re-evaluation yields select 10 and no stall.
// - Two-state FSM: RUN <-> LSTALL. LSTALL lasts exactly 1 cycle and always returns to RUN, even if ins_valid drops.
// - While stalled, selects are held at their previous values; EX carries the bubble.
// - Both operands matching: selects are resolved independently. A == B == EX.dest with EX not LD gives 01/01.
// - Unused-source matches never stall and never forward.
// - Same dest in several stages: the nearest stage wins.
// - RW_wb = WB.dest; wb_en = WB.valid & WB.wr (0 for R0 when R0_HARDWIRED).
// - Reset (any time, including mid-stall): all valids 0, FSM=RUN, mux_sel_A/B=00, RW_wb=0, wb_en=0, ins_ready=1. Issued instructions in flight are discarded.
// CONFIGURATION
// - FORWARD_EN defined: bypass behaviour as above.
// - FORWARD_EN undefined: mux_sel_A/B are constant 00.
// - Without FORWARD_EN, ins_ready = 0 while any used source matches EX, MEM or WB, for any opcode. Stalls repeat until the producer retires past WB.
// - Without FORWARD_EN, the LSTALL state is unused.
// TESTING
// - ALU D=3 A=1 B=2, then ALU D=4 A=3 B=5 back-to-back -> 2nd EX cycle: sel_A=01, sel_B=00, no stall.
// - ALU D=3, NOP, NOP, ALU A=3 B=3 -> sel_A=11, sel_B=11; 3rd cycle after the first issue: RW_wb=3, wb_en=1.
// - LD D=7 A=1, then ALU A=7 B=2 -> ins_ready=0 for 1 cycle, 1 bubble; ALU then issues with sel_A=10.
// - LD D=7, then IMM D=8 A=2 with B field=7 -> no stall, sel_B=00.
// - ALU D=0 A=1 B=2, then ALU A=0 -> sel_A=00, wb_en=0 when that ALU reaches WB (R0_HARDWIRED=1).
// - reset low during LSTALL -> selects 00, ins_ready=1, wb_en=0 next cycle. Without FORWARD_EN, ALU D=3 then ALU A=3 -> 3 stall cycles, then sel_A=00.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks in-flight destinations across EX/MEM/WB, stalls on load-use
// and drives operand bypass selects. Bypassing is built only when `FORWARD_EN is defined.
module hazard_forward_unit #(
  parameter int ADDR_W       = 5,
  parameter int R0_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic              ins_valid,
  output logic              ins_ready,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic              stall,
  output logic [ADDR_W-1:0] RW_wb,
  output logic              wb_en
);

  typedef enum logic {S_RUN, S_LSTALL} state_t;

  localparam logic [1:0] SEL_RF = 2'b00;

  function automatic logic match_fn(input logic              vld,
                                    input logic              wr,
                                    input logic [ADDR_W-1:0] dest,
                                    input logic [ADDR_W-1:0] src);
    return vld && wr && (dest == src) && !((R0_HARDWIRED != 0) && (dest == '0));
  endfunction

  logic [5:0]        op;
  logic              is_jmp, is_cj, is_ld, is_st, is_imm, is_alu;
  logic              dec_wr, rd_a, rd_b;
  logic [ADDR_W-1:0] dec_d, src_a, src_b;

  assign op     = ins[31:26];
  assign is_jmp = (op == 6'b011000);
  assign is_cj  = (op[5:2] == 4'b0111);
  assign is_ld  = (op == 6'b010100);
  assign is_st  = (op == 6'b010101);
  assign is_imm = (op[5:3] == 3'b001);
  assign is_alu = !(is_jmp || is_cj || is_ld || is_st || is_imm);
  assign dec_wr = is_alu || is_imm || is_ld;
  assign rd_a   = !is_jmp;
  assign rd_b   = is_alu || is_cj || is_st;
  assign dec_d  = ins[21 +: ADDR_W];
  assign src_a  = ins[16 +: ADDR_W];
  assign src_b  = ins[11 +: ADDR_W];

  // stage records: _p0 = EX, _p1 = MEM, _p2 = WB
  logic              vld_p0, vld_p1, vld_p2;
  logic              wr_p0, wr_p1, wr_p2;
  logic              ld_p0, ld_p1, ld_p2;
  logic [ADDR_W-1:0] dest_p0, dest_p1, dest_p2;

  logic hit_a_p0, hit_a_p1, hit_a_p2;
  logic hit_b_p0, hit_b_p1, hit_b_p2;

  // unused-source hits are masked here so they neither stall nor forward
  assign hit_a_p0 = rd_a && match_fn(vld_p0, wr_p0, dest_p0, src_a);
  assign hit_a_p1 = rd_a && match_fn(vld_p1, wr_p1, dest_p1, src_a);
  assign hit_a_p2 = rd_a && match_fn(vld_p2, wr_p2, dest_p2, src_a);
  assign hit_b_p0 = rd_b && match_fn(vld_p0, wr_p0, dest_p0, src_b);
  assign hit_b_p1 = rd_b && match_fn(vld_p1, wr_p1, dest_p1, src_b);
  assign hit_b_p2 = rd_b && match_fn(vld_p2, wr_p2, dest_p2, src_b);

  logic dep_stall;

`ifdef FORWARD_EN
  assign dep_stall = ins_valid && ld_p0 && (hit_a_p0 || hit_b_p0);
`else
  assign dep_stall = ins_valid && (hit_a_p0 || hit_a_p1 || hit_a_p2 ||
                                   hit_b_p0 || hit_b_p1 || hit_b_p2);
`endif

  state_t state, state_nx;
  logic   issue;

  always_comb begin
    state_nx  = state;
    ins_ready = 1'b1;
    case (state)
      S_RUN: begin
        if (dep_stall) begin
          ins_ready = 1'b0;
`ifdef FORWARD_EN
          state_nx  = S_LSTALL;
`endif
        end
      end
      S_LSTALL: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RUN;
    else        state <= state_nx;
  end

  assign issue = ins_valid && ins_ready;
  assign stall = !ins_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      wr_p0   <= 1'b0;
      ld_p0   <= 1'b0;
      dest_p0 <= '0;
      vld_p1  <= 1'b0;
      wr_p1   <= 1'b0;
      ld_p1   <= 1'b0;
      dest_p1 <= '0;
      vld_p2  <= 1'b0;
      wr_p2   <= 1'b0;
      ld_p2   <= 1'b0;
      dest_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      wr_p2   <= wr_p1;
      ld_p2   <= ld_p1;
      dest_p2 <= dest_p1;
      vld_p1  <= vld_p0;
      wr_p1   <= wr_p0;
      ld_p1   <= ld_p0;
      dest_p1 <= dest_p0;
      if (issue) begin
        vld_p0  <= 1'b1;
        wr_p0   <= dec_wr;
        ld_p0   <= is_ld;
        dest_p0 <= dec_d;
      end else begin
        vld_p0  <= 1'b0;
        wr_p0   <= 1'b0;
        ld_p0   <= 1'b0;
        dest_p0 <= '0;
      end
    end
  end

`ifdef FORWARD_EN
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  function automatic logic [1:0] prio_fn(input logic h_ex, input logic h_mem, input logic h_wb);
    if (h_ex)  return SEL_EX;
    if (h_mem) return SEL_MEM;
    if (h_wb)  return SEL_WB;
    return SEL_RF;
  endfunction

  logic [1:0] sel_a_p0, sel_b_p0;

  // selects are captured on the issue edge and held across stalls and idle cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_a_p0 <= SEL_RF;
      sel_b_p0 <= SEL_RF;
    end else if (issue) begin
      sel_a_p0 <= prio_fn(hit_a_p0, hit_a_p1, hit_a_p2);
      sel_b_p0 <= prio_fn(hit_b_p0, hit_b_p1, hit_b_p2);
    end
  end

  assign mux_sel_A = sel_a_p0;
  assign mux_sel_B = sel_b_p0;
`else
  assign mux_sel_A = SEL_RF;
  assign mux_sel_B = SEL_RF;
`endif

  assign RW_wb = dest_p2;
  assign wb_en = vld_p2 && wr_p2 && !((R0_HARDWIRED != 0) && (dest_p2 == '0));

  logic unused_ok;
  assign unused_ok = ^{ins, ld_p0, ld_p1, ld_p2};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; covers both the FORWARD_EN build and the default build.
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [1:0]  mux_sel_A;
  logic [1:0]  mux_sel_B;
  logic        stall;
  logic [4:0]  RW_wb;
  logic        wb_en;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] OP_ALU = 6'b000000;
  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_ST  = 6'b010101;
  localparam logic [5:0] OP_IMM = 6'b001000;
  localparam logic [5:0] OP_JMP = 6'b011000;

  hazard_forward_unit #(.ADDR_W(5), .R0_HARDWIRED(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .mux_sel_A (mux_sel_A),
    .mux_sel_B (mux_sel_B),
    .stall     (stall),
    .RW_wb     (RW_wb),
    .wb_en     (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                     input logic [4:0] a, input logic [4:0] b);
    return {op, d, a, b, 11'd0};
  endfunction

  // one clock: drive just after the rising edge, return at the falling edge for sampling
  task automatic cyc(input logic [31:0] i, input logic v);
    @(posedge clk);
    #1;
    ins       = i;
    ins_valid = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(32'd0, 1'b0);
  endtask

  task automatic rel();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ins_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic hit_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    reset     = 1'b0;
    ins       = 32'd0;
    ins_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ins_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_selA", 32'(mux_sel_A), 32'd0);
    chk("rst_selB", 32'(mux_sel_B), 32'd0);
    chk("rst_rw", 32'(RW_wb), 32'd0);
    chk("rst_wben", 32'(wb_en), 32'd0);
    rel();

    // writeback address and enable three cycles after issue
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1);
    chk("wb_issue_ready", 32'(ins_ready), 32'd1);
    idle(2);
    chk("wb_mem_wben", 32'(wb_en), 32'd0);
    idle(1);
    chk("wb_rw", 32'(RW_wb), 32'd3);
    chk("wb_en", 32'(wb_en), 32'd1);
    idle(3);

    // destination R0 never enables writeback
    cyc(mk(OP_ALU, 5'd0, 5'd1, 5'd2), 1'b1);
    cyc(mk(OP_ALU, 5'd12, 5'd0, 5'd0), 1'b1);
    chk("r0_nostall", 32'(ins_ready), 32'd1);
    idle(1);
    chk("r0_selA", 32'(mux_sel_A), 32'd0);
    chk("r0_selB", 32'(mux_sel_B), 32'd0);
    idle(1);
    chk("r0_wben", 32'(wb_en), 32'd0);
    chk("r0_rw", 32'(RW_wb), 32'd0);
    idle(3);

    // unused sources and non-writing producers
    cyc(mk(OP_ALU, 5'd9, 5'd1, 5'd2), 1'b1);
    cyc(mk(OP_IMM, 5'd8, 5'd2, 5'd9), 1'b1);
    chk("imm_b_nostall", 32'(ins_ready), 32'd1);
    cyc(mk(OP_JMP, 5'd0, 5'd9, 5'd9), 1'b1);
    chk("imm_selB", 32'(mux_sel_B), 32'd0);
    chk("jmp_nostall", 32'(ins_ready), 32'd1);
    cyc(mk(OP_ST, 5'd9, 5'd1, 5'd2), 1'b1);
    chk("jmp_selA", 32'(mux_sel_A), 32'd0);
    chk("st_ready", 32'(ins_ready), 32'd1);
    cyc(mk(OP_ALU, 5'd12, 5'd9, 5'd9), 1'b1);
    chk("after_st_ready", 32'(ins_ready), 32'd1);
    idle(1);
    chk("after_st_selA", 32'(mux_sel_A), 32'd0);
    idle(3);

`ifdef FORWARD_EN
    // back-to-back ALU: EX bypass on A
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1);
    cyc(mk(OP_ALU, 5'd4, 5'd3, 5'd5), 1'b1);
    chk("f1_ready", 32'(ins_ready), 32'd1);
    idle(1);
    chk("f1_selA", 32'(mux_sel_A), 32'd1);
    chk("f1_selB", 32'(mux_sel_B), 32'd0);
    idle(3);

    // producer in WB for both operands
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1);
    idle(2);
    cyc(mk(OP_ALU, 5'd10, 5'd3, 5'd3), 1'b1);
    chk("f2_rw", 32'(RW_wb), 32'd3);
    chk("f2_wben", 32'(wb_en), 32'd1);
    idle(1);
    chk("f2_selA", 32'(mux_sel_A), 32'd3);
    chk("f2_selB", 32'(mux_sel_B), 32'd3);
    idle(3);

    // load-use: one stall, one bubble, then MEM bypass
    cyc(mk(OP_LD, 5'd7, 5'd1, 5'd0), 1'b1);
    cyc(mk(OP_ALU, 5'd11, 5'd7, 5'd2), 1'b1);
    chk("f3_ready", 32'(ins_ready), 32'd0);
    chk("f3_stall", 32'(stall), 32'd1);
    chk("f3_hold_selA", 32'(mux_sel_A), 32'd0);
    cyc(mk(OP_ALU, 5'd11, 5'd7, 5'd2), 1'b1);
    chk("f3_lstall_ready", 32'(ins_ready), 32'd1);
    idle(1);
    chk("f3_selA", 32'(mux_sel_A), 32'd2);
    chk("f3_selB", 32'(mux_sel_B), 32'd0);
    chk("f3_wb_ld", 32'(RW_wb), 32'd7);
    idle(1);
    chk("f3_bubble_wben", 32'(wb_en), 32'd0);
    idle(1);
    chk("f3_wb_alu", 32'(RW_wb), 32'd11);
    chk("f3_wb_alu_en", 32'(wb_en), 32'd1);
    idle(3);

    // load followed by IMM whose B field names the load target
    cyc(mk(OP_LD, 5'd7, 5'd1, 5'd0), 1'b1);
    cyc(mk(OP_IMM, 5'd8, 5'd2, 5'd7), 1'b1);
    chk("f4_ready", 32'(ins_ready), 32'd1);
    idle(1);
    chk("f4_selB", 32'(mux_sel_B), 32'd0);
    chk("f4_selA", 32'(mux_sel_A), 32'd0);
    idle(3);

    // nearest stage wins (MEM over WB)
    cyc(mk(OP_ALU, 5'd5, 5'd1, 5'd2), 1'b1);
    cyc(mk(OP_ALU, 5'd5, 5'd1, 5'd2), 1'b1);
    idle(1);
    cyc(mk(OP_ALU, 5'd13, 5'd5, 5'd2), 1'b1);
    idle(1);
    chk("f6_selA", 32'(mux_sel_A), 32'd2);
    idle(3);

    // reset while in the post-load stall cycle
    cyc(mk(OP_ALU, 5'd1, 5'd2, 5'd2), 1'b1);
    cyc(mk(OP_LD, 5'd7, 5'd1, 5'd0), 1'b1);
    cyc(mk(OP_ALU, 5'd14, 5'd7, 5'd2), 1'b1);
    chk("f7_stall", 32'(stall), 32'd1);
    chk("f7_hold_selA", 32'(mux_sel_A), 32'd1);
    hit_reset();
    chk("f7_rst_selA", 32'(mux_sel_A), 32'd0);
    chk("f7_rst_ready", 32'(ins_ready), 32'd1);
    chk("f7_rst_wben", 32'(wb_en), 32'd0);
    rel();
    idle(3);
`else
    // no bypass: stall until the producer leaves WB
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(mk(OP_ALU, 5'd4, 5'd3, 5'd5), 1'b1);
      if (ins_ready) break;
      cnt++;
    end
    chk("n1_stall_cycles", 32'(cnt), 32'd3);
    idle(1);
    chk("n1_selA", 32'(mux_sel_A), 32'd0);
    chk("n1_selB", 32'(mux_sel_B), 32'd0);
    idle(3);

    // a load producer behaves the same way
    cyc(mk(OP_LD, 5'd7, 5'd1, 5'd0), 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(mk(OP_ALU, 5'd11, 5'd2, 5'd7), 1'b1);
      if (ins_ready) break;
      cnt++;
    end
    chk("n2_stall_cycles", 32'(cnt), 32'd3);
    idle(4);

    // reset during a dependency stall
    cyc(mk(OP_ALU, 5'd1, 5'd4, 5'd4), 1'b1);
    cyc(mk(OP_ALU, 5'd2, 5'd4, 5'd4), 1'b1);
    chk("n3_indep_ready", 32'(ins_ready), 32'd1);
    cyc(mk(OP_ALU, 5'd15, 5'd2, 5'd4), 1'b1);
    chk("n3_stall", 32'(stall), 32'd1);
    hit_reset();
    chk("n3_rst_ready", 32'(ins_ready), 32'd1);
    chk("n3_rst_wben", 32'(wb_en), 32'd0);
    chk("n3_rst_selA", 32'(mux_sel_A), 32'd0);
    rel();
    idle(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
